// File: rtl/ae18_wbmem_if.sv
// Bus bundle for the AE18 dual-port Wishbone memory: 16-bit instruction port and 8-bit data port.
interface ae18_wbmem_if #(
    parameter int IAW = 16,
    parameter int DAW = 10
);
    logic [IAW-1:1] iwb_adr_i;
    logic [15:0]    iwb_dat_i;
    logic [1:0]     iwb_sel_i;
    logic           iwb_we_i;
    logic           iwb_stb_i;
    logic [15:0]    iwb_dat_o;
    logic           iwb_ack_o;

    logic [DAW-1:0] dwb_adr_i;
    logic [7:0]     dwb_dat_i;
    logic           dwb_we_i;
    logic           dwb_stb_i;
    logic [7:0]     dwb_dat_o;
    logic           dwb_ack_o;

    modport slave (
        input  iwb_adr_i, iwb_dat_i, iwb_sel_i, iwb_we_i, iwb_stb_i,
        output iwb_dat_o, iwb_ack_o,
        input  dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_stb_i,
        output dwb_dat_o, dwb_ack_o
    );

    modport master (
        output iwb_adr_i, iwb_dat_i, iwb_sel_i, iwb_we_i, iwb_stb_i,
        input  iwb_dat_o, iwb_ack_o,
        output dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_stb_i,
        input  dwb_dat_o, dwb_ack_o
    );
endinterface

// File: rtl/ae18_wbmem.sv
// Dual-port Wishbone memory for AE18: separate instruction (16-bit, byte lanes) and data (8-bit) arrays,
// each port with its own IDLE/WAIT/ACK responder, programmable wait states and strobe-abort.
module ae18_wbmem #(
    parameter int IAW   = 16,
    parameter int DAW   = 10,
    parameter int IWAIT = 0,
    parameter int DWAIT = 0,
    parameter int WW    = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ae18_wbmem_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [WW-1:0] ILOAD = WW'((IWAIT > 0) ? IWAIT - 1 : 0);
    localparam logic [WW-1:0] DLOAD = WW'((DWAIT > 0) ? DWAIT - 1 : 0);

    logic [15:0] imem [2**(IAW-1)];
    logic [7:0]  dmem [2**DAW];

    state_t         i_state;
    logic [WW-1:0]  i_cnt;
    logic [IAW-1:1] i_adr;
    logic [15:0]    i_dat;
    logic [1:0]     i_sel;
    logic           i_we;
    logic           i_commit, i_cwe;
    logic [IAW-1:1] i_cadr;
    logic [15:0]    i_new;

    state_t         d_state;
    logic [WW-1:0]  d_cnt;
    logic [DAW-1:0] d_adr;
    logic [7:0]     d_dat;
    logic           d_we;
    logic           d_commit, d_cwe;
    logic [DAW-1:0] d_cadr;
    logic [7:0]     d_new;

    // With zero wait states the commit happens on the sampling edge, so the bus is used directly.
    always_comb begin
        i_commit = 1'b0;
        if (bus.iwb_stb_i) begin
            if (i_state == IDLE)      i_commit = (IWAIT == 0);
            else if (i_state == WAIT) i_commit = (i_cnt == '0);
        end
        i_cadr = (i_state == IDLE) ? bus.iwb_adr_i : i_adr;
        i_cwe  = (i_state == IDLE) ? bus.iwb_we_i  : i_we;
        i_new  = imem[i_cadr];
        if (i_cwe) begin
            if ((i_state == IDLE) ? bus.iwb_sel_i[0] : i_sel[0])
                i_new[7:0]  = (i_state == IDLE) ? bus.iwb_dat_i[7:0]  : i_dat[7:0];
            if ((i_state == IDLE) ? bus.iwb_sel_i[1] : i_sel[1])
                i_new[15:8] = (i_state == IDLE) ? bus.iwb_dat_i[15:8] : i_dat[15:8];
        end
    end

    always_comb begin
        d_commit = 1'b0;
        if (bus.dwb_stb_i) begin
            if (d_state == IDLE)      d_commit = (DWAIT == 0);
            else if (d_state == WAIT) d_commit = (d_cnt == '0);
        end
        d_cadr = (d_state == IDLE) ? bus.dwb_adr_i : d_adr;
        d_cwe  = (d_state == IDLE) ? bus.dwb_we_i  : d_we;
        d_new  = dmem[d_cadr];
        if (d_cwe) d_new = (d_state == IDLE) ? bus.dwb_dat_i : d_dat;
    end

    // Arrays are not reset; a clock edge while reset is held must not write.
    always_ff @(posedge clk_i) begin
        if (rst_i && i_commit && i_cwe) imem[i_cadr] <= i_new;
        if (rst_i && d_commit && d_cwe) dmem[d_cadr] <= d_new;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            i_state       <= IDLE;
            i_cnt         <= '0;
            i_adr         <= '0;
            i_dat         <= '0;
            i_sel         <= '0;
            i_we          <= 1'b0;
            bus.iwb_ack_o <= 1'b0;
            bus.iwb_dat_o <= 16'h0000;
        end else begin
            case (i_state)
                IDLE: if (bus.iwb_stb_i) begin
                    i_adr <= bus.iwb_adr_i;
                    i_dat <= bus.iwb_dat_i;
                    i_sel <= bus.iwb_sel_i;
                    i_we  <= bus.iwb_we_i;
                    if (i_commit) begin
                        i_state       <= ACK;
                        bus.iwb_ack_o <= 1'b1;
                        bus.iwb_dat_o <= i_new;
                    end else begin
                        i_cnt   <= ILOAD;
                        i_state <= WAIT;
                    end
                end
                WAIT: if (!bus.iwb_stb_i) begin
                    i_state <= IDLE;
                end else if (i_commit) begin
                    i_state       <= ACK;
                    bus.iwb_ack_o <= 1'b1;
                    bus.iwb_dat_o <= i_new;
                end else begin
                    i_cnt <= i_cnt - 1'b1;
                end
                ACK: begin
                    bus.iwb_ack_o <= 1'b0;
                    i_state       <= IDLE;
                end
                default: i_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            d_state       <= IDLE;
            d_cnt         <= '0;
            d_adr         <= '0;
            d_dat         <= '0;
            d_we          <= 1'b0;
            bus.dwb_ack_o <= 1'b0;
            bus.dwb_dat_o <= 8'h00;
        end else begin
            case (d_state)
                IDLE: if (bus.dwb_stb_i) begin
                    d_adr <= bus.dwb_adr_i;
                    d_dat <= bus.dwb_dat_i;
                    d_we  <= bus.dwb_we_i;
                    if (d_commit) begin
                        d_state       <= ACK;
                        bus.dwb_ack_o <= 1'b1;
                        bus.dwb_dat_o <= d_new;
                    end else begin
                        d_cnt   <= DLOAD;
                        d_state <= WAIT;
                    end
                end
                WAIT: if (!bus.dwb_stb_i) begin
                    d_state <= IDLE;
                end else if (d_commit) begin
                    d_state       <= ACK;
                    bus.dwb_ack_o <= 1'b1;
                    bus.dwb_dat_o <= d_new;
                end else begin
                    d_cnt <= d_cnt - 1'b1;
                end
                ACK: begin
                    bus.dwb_ack_o <= 1'b0;
                    d_state       <= IDLE;
                end
                default: d_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ae18_wbmem.sv
// Directed bench for ae18_wbmem: instance A (IWAIT=2, DWAIT=0) and instance B (IWAIT=5, DWAIT=3).
module tb_ae18_wbmem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ae18_wbmem_if #(.IAW(8), .DAW(10)) bus_a ();
    ae18_wbmem_if #(.IAW(8), .DAW(10)) bus_b ();

    ae18_wbmem #(.IAW(8), .DAW(10), .IWAIT(2), .DWAIT(0), .WW(4)) u_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    ae18_wbmem #(.IAW(8), .DAW(10), .IWAIT(5), .DWAIT(3), .WW(4)) u_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All transfer tasks start and end on a falling edge.
    task automatic ia_xfer(input logic [7:1] adr, input logic we, input logic [15:0] dat,
                           input logic [1:0] sel, output int lat, output logic [15:0] rd,
                           output logic ack2);
        bus_a.iwb_adr_i = adr; bus_a.iwb_we_i = we; bus_a.iwb_dat_i = dat;
        bus_a.iwb_sel_i = sel; bus_a.iwb_stb_i = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!bus_a.iwb_ack_o && lat < 40);
        rd = bus_a.iwb_dat_o;
        bus_a.iwb_stb_i = 1'b0; bus_a.iwb_we_i = 1'b0;
        @(negedge clk); ack2 = bus_a.iwb_ack_o;
    endtask

    task automatic ib_xfer(input logic [7:1] adr, input logic we, input logic [15:0] dat,
                           output int lat, output logic [15:0] rd);
        bus_b.iwb_adr_i = adr; bus_b.iwb_we_i = we; bus_b.iwb_dat_i = dat;
        bus_b.iwb_sel_i = 2'b11; bus_b.iwb_stb_i = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!bus_b.iwb_ack_o && lat < 40);
        rd = bus_b.iwb_dat_o;
        bus_b.iwb_stb_i = 1'b0; bus_b.iwb_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic da_xfer(input logic [9:0] adr, input logic we, input logic [7:0] dat,
                           output int lat, output logic [7:0] rd, output logic ack2);
        bus_a.dwb_adr_i = adr; bus_a.dwb_we_i = we; bus_a.dwb_dat_i = dat;
        bus_a.dwb_stb_i = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!bus_a.dwb_ack_o && lat < 40);
        rd = bus_a.dwb_dat_o;
        bus_a.dwb_stb_i = 1'b0; bus_a.dwb_we_i = 1'b0;
        @(negedge clk); ack2 = bus_a.dwb_ack_o;
    endtask

    task automatic db_xfer(input logic [9:0] adr, input logic we, input logic [7:0] dat,
                           output int lat, output logic [7:0] rd);
        bus_b.dwb_adr_i = adr; bus_b.dwb_we_i = we; bus_b.dwb_dat_i = dat;
        bus_b.dwb_stb_i = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!bus_b.dwb_ack_o && lat < 40);
        rd = bus_b.dwb_dat_o;
        bus_b.dwb_stb_i = 1'b0; bus_b.dwb_we_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat, acks, iacks, dacks;
        logic        ack2;
        logic [15:0] rd16;
        logic [7:0]  rd8;

        bus_a.iwb_adr_i = '0; bus_a.iwb_dat_i = '0; bus_a.iwb_sel_i = 2'b11;
        bus_a.iwb_we_i = 1'b0; bus_a.iwb_stb_i = 1'b1;
        bus_a.dwb_adr_i = '0; bus_a.dwb_dat_i = '0; bus_a.dwb_we_i = 1'b0; bus_a.dwb_stb_i = 1'b1;
        bus_b.iwb_adr_i = '0; bus_b.iwb_dat_i = '0; bus_b.iwb_sel_i = 2'b11;
        bus_b.iwb_we_i = 1'b0; bus_b.iwb_stb_i = 1'b1;
        bus_b.dwb_adr_i = '0; bus_b.dwb_dat_i = '0; bus_b.dwb_we_i = 1'b0; bus_b.dwb_stb_i = 1'b1;

        // Reset held with strobes high
        repeat (3) @(negedge clk);
        check("rst_a_iack", 32'(bus_a.iwb_ack_o), 32'd0);
        check("rst_a_dack", 32'(bus_a.dwb_ack_o), 32'd0);
        check("rst_a_idat", 32'(bus_a.iwb_dat_o), 32'h0000);
        check("rst_a_ddat", 32'(bus_a.dwb_dat_o), 32'h00);
        check("rst_b_iack", 32'(bus_b.iwb_ack_o), 32'd0);
        check("rst_b_ddat", 32'(bus_b.dwb_dat_o), 32'h00);

        // Release with strobes still high: A data ack one cycle later
        rst = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!bus_a.dwb_ack_o && lat < 40);
        check("rel_a_dlat", 32'(lat), 32'd1);
        bus_a.iwb_stb_i = 1'b0; bus_a.dwb_stb_i = 1'b0;
        bus_b.iwb_stb_i = 1'b0; bus_b.dwb_stb_i = 1'b0;
        repeat (2) @(negedge clk);

        // Data port, zero wait states
        da_xfer(10'h123, 1'b1, 8'hA5, lat, rd8, ack2);
        check("da_wr_lat", 32'(lat), 32'd1);
        check("da_wr_ack1", 32'(ack2), 32'd0);
        da_xfer(10'h123, 1'b0, 8'h00, lat, rd8, ack2);
        check("da_rd_lat", 32'(lat), 32'd1);
        check("da_rd_dat", 32'(rd8), 32'hA5);
        check("da_rd_ack1", 32'(ack2), 32'd0);
        check("da_hold", 32'(bus_a.dwb_dat_o), 32'hA5);

        // Data port, three wait states
        db_xfer(10'h040, 1'b1, 8'h3C, lat, rd8);
        check("db_wr_lat", 32'(lat), 32'd4);
        db_xfer(10'h040, 1'b0, 8'h00, lat, rd8);
        check("db_rd_lat", 32'(lat), 32'd4);
        check("db_rd_dat", 32'(rd8), 32'h3C);
        db_xfer(10'h040, 1'b0, 8'h00, lat, rd8);
        check("db_wrap_hi", 32'(rd8), 32'h3C);

        // Instruction byte lanes
        ia_xfer(7'd5, 1'b1, 16'h1234, 2'b11, lat, rd16, ack2);
        check("ia_wr11_lat", 32'(lat), 32'd3);
        check("ia_wr11_dat", 32'(rd16), 32'h1234);
        check("ia_wr11_ack1", 32'(ack2), 32'd0);
        ia_xfer(7'd5, 1'b1, 16'hABCD, 2'b10, lat, rd16, ack2);
        check("ia_wr10_dat", 32'(rd16), 32'hAB34);
        ia_xfer(7'd5, 1'b0, 16'h0000, 2'b11, lat, rd16, ack2);
        check("ia_rd_dat", 32'(rd16), 32'hAB34);
        ia_xfer(7'd5, 1'b1, 16'h5555, 2'b00, lat, rd16, ack2);
        check("ia_wr00_lat", 32'(lat), 32'd3);
        check("ia_wr00_dat", 32'(rd16), 32'hAB34);
        ia_xfer(7'd5, 1'b1, 16'h00EF, 2'b01, lat, rd16, ack2);
        check("ia_wr01_dat", 32'(rd16), 32'hABEF);
        ia_xfer(7'd5, 1'b0, 16'h0000, 2'b11, lat, rd16, ack2);
        check("ia_rd2_dat", 32'(rd16), 32'hABEF);

        // Abort during WAIT on B data port
        db_xfer(10'h007, 1'b1, 8'h00, lat, rd8);
        bus_b.dwb_adr_i = 10'h007; bus_b.dwb_we_i = 1'b1; bus_b.dwb_dat_i = 8'h55;
        bus_b.dwb_stb_i = 1'b1; acks = 0;
        repeat (2) begin @(negedge clk); if (bus_b.dwb_ack_o) acks++; end
        bus_b.dwb_stb_i = 1'b0; bus_b.dwb_we_i = 1'b0;
        repeat (6) begin @(negedge clk); if (bus_b.dwb_ack_o) acks++; end
        check("abort_no_ack", 32'(acks), 32'd0);
        db_xfer(10'h007, 1'b0, 8'h00, lat, rd8);
        check("abort_rd_lat", 32'(lat), 32'd4);
        check("abort_rd_dat", 32'(rd8), 32'h00);

        // Reset during WAIT on B instruction port
        ib_xfer(7'd9, 1'b1, 16'hBEEF, lat, rd16);
        check("ib_wr_lat", 32'(lat), 32'd6);
        bus_b.iwb_adr_i = 7'd9; bus_b.iwb_we_i = 1'b1; bus_b.iwb_dat_i = 16'h1111;
        bus_b.iwb_sel_i = 2'b11; bus_b.iwb_stb_i = 1'b1; acks = 0;
        repeat (2) begin @(negedge clk); if (bus_b.iwb_ack_o) acks++; end
        rst = 1'b0; bus_b.iwb_stb_i = 1'b0; bus_b.iwb_we_i = 1'b0;
        @(negedge clk); if (bus_b.iwb_ack_o) acks++;
        rst = 1'b1;
        repeat (10) begin @(negedge clk); if (bus_b.iwb_ack_o) acks++; end
        check("rstmid_no_ack", 32'(acks), 32'd0);
        check("rstmid_dat_clr", 32'(bus_b.iwb_dat_o), 32'h0000);
        ib_xfer(7'd9, 1'b0, 16'h0000, lat, rd16);
        check("rstmid_word", 32'(rd16), 32'hBEEF);

        // Concurrent ports on A for 12 cycles
        bus_a.iwb_adr_i = 7'd5; bus_a.iwb_we_i = 1'b0; bus_a.iwb_stb_i = 1'b1;
        bus_a.dwb_adr_i = 10'h123; bus_a.dwb_we_i = 1'b0; bus_a.dwb_stb_i = 1'b1;
        iacks = 0; dacks = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_a.iwb_ack_o) begin iacks++; check("conc_idat", 32'(bus_a.iwb_dat_o), 32'hABEF); end
            if (bus_a.dwb_ack_o) begin dacks++; check("conc_ddat", 32'(bus_a.dwb_dat_o), 32'hA5); end
        end
        bus_a.iwb_stb_i = 1'b0; bus_a.dwb_stb_i = 1'b0;
        check("conc_iacks", 32'(iacks), 32'd3);
        check("conc_dacks", 32'(dacks), 32'd6);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
